// File: rtl/ledring_tx.sv
// rtl/ledring_tx.sv - WS2812-style pixel ring transmitter; define LEDRING_BRIGHTNESS_EN to add brightness scaling.
// Start-accept edge to done edge is exactly 1 + 24*NUM_LEDS*BIT_CYC + LATCH_CYC cycles.
module ledring_tx #(
    parameter int NUM_LEDS  = 16,
    parameter int T0H_CYC   = 20,
    parameter int T1H_CYC   = 40,
    parameter int BIT_CYC   = 63,
    parameter int LATCH_CYC = 15000,
    parameter int AW        = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] pix_addr,
    output logic          pix_rd,
`ifdef LEDRING_BRIGHTNESS_EN
    input  logic [7:0]    brightness,
`endif
    input  logic [23:0]   pix_data,
    output logic          ledring_n
);

    localparam int CMAX = (LATCH_CYC > BIT_CYC) ? LATCH_CYC : BIT_CYC;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0] BIT_LAST   = CW'(BIT_CYC - 1);
    localparam logic [CW-1:0] LATCH_LAST = CW'(LATCH_CYC - 1);
    localparam logic [CW-1:0] T0H        = CW'(T0H_CYC);
    localparam logic [CW-1:0] T1H        = CW'(T1H_CYC);
    localparam logic [AW-1:0] PIX_LAST   = AW'(NUM_LEDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SHIFT, S_LATCH} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [4:0]     bit_q, bit_d;
    logic [AW-1:0]  pix_q, pix_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [23:0]    shift_q, shift_d;
    logic [23:0]    word_q, word_d;
    logic           rd_q, rd_d;
    logic           rd_dly_q;
    logic           ledring_n_q, ledring_n_d;
    logic           done_q, done_d;
    logic           boot_q, boot_d;

    logic [23:0]    cap_val;
    logic           cur_bit;
    logic [CW-1:0]  th;

`ifdef LEDRING_BRIGHTNESS_EN
    function automatic logic [7:0] scale8(input logic [7:0] ch, input logic [7:0] lvl);
        logic [15:0] prod;
        prod = 16'(ch) * (16'(lvl) + 16'd1);
        return 8'(prod >> 8);
    endfunction

    assign cap_val = {scale8(pix_data[23:16], brightness),
                      scale8(pix_data[15:8],  brightness),
                      scale8(pix_data[7:0],   brightness)};
`else
    assign cap_val = pix_data;
`endif

    // Pixel 0 is captured during its own first bit cycle, so its MSB comes straight from the bus.
    assign cur_bit = (rd_dly_q && bit_q == 5'd0) ? cap_val[23] : shift_q[23];
    assign th      = cur_bit ? T1H : T0H;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        pix_d       = pix_q;
        addr_d      = addr_q;
        shift_d     = shift_q;
        word_d      = word_q;
        rd_d        = 1'b0;
        ledring_n_d = 1'b1;
        done_d      = 1'b0;
        boot_d      = boot_q;

        if (rd_dly_q) begin
            if (bit_q == 5'd0) shift_d = cap_val;
            else               word_d  = cap_val;
        end

        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (boot_q) begin
                    state_d = S_LATCH;
                end else if (start) begin
                    state_d = S_FETCH;
                    rd_d    = 1'b1;
                    addr_d  = '0;
                    pix_d   = '0;
                    bit_d   = '0;
                end
            end
            S_FETCH: begin
                state_d     = S_SHIFT;
                cnt_d       = '0;
                ledring_n_d = 1'b0;
            end
            S_SHIFT: begin
                if (bit_q == 5'd23 && cnt_q == '0 && pix_q != PIX_LAST) begin
                    rd_d   = 1'b1;
                    addr_d = pix_q + AW'(1);
                end
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (bit_q != 5'd23) begin
                        bit_d       = bit_q + 5'd1;
                        shift_d     = {shift_q[22:0], 1'b0};
                        ledring_n_d = 1'b0;
                    end else if (pix_q != PIX_LAST) begin
                        bit_d       = '0;
                        pix_d       = pix_q + AW'(1);
                        shift_d     = word_q;
                        ledring_n_d = 1'b0;
                    end else begin
                        state_d = S_LATCH;
                    end
                end else begin
                    cnt_d       = cnt_q + CW'(1);
                    ledring_n_d = (cnt_d >= th);
                end
            end
            S_LATCH: begin
                if (cnt_q == LATCH_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    done_d  = !boot_q;
                    boot_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            pix_q       <= '0;
            addr_q      <= '0;
            shift_q     <= '0;
            word_q      <= '0;
            rd_q        <= 1'b0;
            rd_dly_q    <= 1'b0;
            ledring_n_q <= 1'b1;
            done_q      <= 1'b0;
            boot_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            pix_q       <= pix_d;
            addr_q      <= addr_d;
            shift_q     <= shift_d;
            word_q      <= word_d;
            rd_q        <= rd_d;
            rd_dly_q    <= rd_q;
            ledring_n_q <= ledring_n_d;
            done_q      <= done_d;
            boot_q      <= boot_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign pix_rd    = rd_q;
    assign pix_addr  = addr_q;
    assign ledring_n = ledring_n_q;

endmodule
